boot_bus_ctrl: RTL and testbench

//  CPU-side bus controller sitting directly upstream of the boot block RAM.
//  - Accepts valid/ready CPU memory requests and decodes the address into BRAM, IO or unmapped.
//  - Drives the RAM's one-cycle select/we/rd strobes and absorbs its registered read latency.
//  - Handshakes variable-latency IO, then returns one registered ready pulse per transaction.

---
 rtl/bus_map_pkg.sv | 42 ++++
 rtl/boot_bus_ctrl_if.sv | 22 ++
 rtl/bus_watchdog.sv | 28 ++
 rtl/boot_bus_ctrl.sv | 172 +++++++++++++++++
 tb/tb_boot_bus_ctrl.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_map_pkg.sv
// bus_map_pkg: address windows, FSM states and the address decoder
// shared by boot_bus_ctrl and its testbench.
package bus_map_pkg;

    localparam logic [31:0] DEF_BRAM_BASE      = 32'h0000_0000;
    localparam int unsigned DEF_BRAM_WORDS     = 512;
    localparam logic [31:0] DEF_IO_BASE        = 32'h8000_0000;
    localparam int unsigned DEF_IO_SPAN        = 256;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam logic [31:0] DEADBEEF           = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRAM_WAIT,
        ST_IO_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        RGN_BRAM,
        RGN_IO,
        RGN_NONE
    } region_e;

    // Offsets wrap below a base, so one unsigned compare covers both ends.
    function automatic region_e decode(
        input logic [31:0] addr,
        input logic [31:0] bram_base,
        input logic [31:0] bram_bytes,
        input logic [31:0] io_base,
        input logic [31:0] io_span
    );
        logic [31:0] ob;
        logic [31:0] oi;
        ob = addr - bram_base;
        oi = addr - io_base;
        if (ob < bram_bytes) return RGN_BRAM;
        if (oi < io_span) return RGN_IO;
        return RGN_NONE;
    endfunction

endpackage

// File: rtl/boot_bus_ctrl_if.sv
// boot_bus_ctrl_if: CPU-side valid/ready memory bus.
// master = CPU, slave = boot_bus_ctrl.
interface boot_bus_ctrl_if;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/bus_watchdog.sv
// bus_watchdog: cycle counter cleared by load_i, advanced by count_i;
// expire_o flags the cycle in which the LIMIT-th counted edge occurs.
module bus_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;

    assign expire_o = count_i && (cnt_q == W'(LIMIT - 1));

    // Count waited cycles; hold at the limit until reloaded.
    always_ff @(posedge clk) begin
        if (!resetn || load_i) begin
            cnt_q <= '0;
        end else if (count_i && !expire_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/boot_bus_ctrl.sv
// boot_bus_ctrl: CPU bus front end for the boot BRAM and an IO window.
// Define BUS_TIMEOUT_EN to add the IO wait watchdog.
module boot_bus_ctrl
    import bus_map_pkg::*;
#(
    parameter logic [31:0] BRAM_BASE      = DEF_BRAM_BASE,
    parameter int unsigned BRAM_WORDS     = DEF_BRAM_WORDS,
    parameter logic [31:0] IO_BASE        = DEF_IO_BASE,
    parameter int unsigned IO_SPAN        = DEF_IO_SPAN
`ifdef BUS_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                  clk,
    input  logic                  resetn,
    boot_bus_ctrl_if.slave        bus,
    output logic                  bram_select,
    output logic [3:0]            bram_we,
    output logic                  bram_rd,
    output logic [11:0]           bram_addr,
    output logic [31:0]           bram_wdata,
    input  logic [31:0]           bram_rdata,
    output logic                  io_valid,
    output logic [7:0]            io_addr,
    output logic [3:0]            io_wstrb,
    output logic [31:0]           io_wdata,
    input  logic [31:0]           io_rdata,
    input  logic                  io_ready,
    output logic                  bus_err
);

    state_e      state_q;
    logic        wr_q;
    logic        rd_pend_q;
    logic        mem_ready_q;
    logic [31:0] mem_rdata_q;
    logic        bram_select_q;
    logic [3:0]  bram_we_q;
    logic        bram_rd_q;
    logic [11:0] bram_addr_q;
    logic [31:0] bram_wdata_q;
    logic        io_valid_q;
    logic [7:0]  io_addr_q;
    logic [3:0]  io_wstrb_q;
    logic [31:0] io_wdata_q;
    logic        bus_err_q;
    region_e     region_d;

    assign region_d = decode(bus.mem_addr, BRAM_BASE,
                             32'(BRAM_WORDS * 4), IO_BASE,
                             32'(IO_SPAN));

`ifdef BUS_TIMEOUT_EN
    logic wd_expire;

    bus_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .resetn   (resetn),
        .load_i   (state_q == ST_IDLE),
        .count_i  (state_q == ST_IO_WAIT),
        .expire_o (wd_expire)
    );
`endif

    // Transaction FSM; every output comes straight from a register here.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            wr_q          <= 1'b0;
            rd_pend_q     <= 1'b0;
            mem_ready_q   <= 1'b0;
            mem_rdata_q   <= '0;
            bram_select_q <= 1'b0;
            bram_we_q     <= '0;
            bram_rd_q     <= 1'b0;
            bram_addr_q   <= '0;
            bram_wdata_q  <= '0;
            io_valid_q    <= 1'b0;
            io_addr_q     <= '0;
            io_wstrb_q    <= '0;
            io_wdata_q    <= '0;
            bus_err_q     <= 1'b0;
        end else begin
            bram_select_q <= 1'b0;
            bram_we_q     <= '0;
            bram_rd_q     <= 1'b0;
            mem_ready_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.mem_valid) begin
                        wr_q      <= |bus.mem_wstrb;
                        rd_pend_q <= 1'b0;
                        unique case (region_d)
                            RGN_BRAM: begin
                                state_q       <= ST_BRAM_WAIT;
                                bram_select_q <= 1'b1;
                                bram_we_q     <= bus.mem_wstrb;
                                bram_rd_q     <= ~|bus.mem_wstrb;
                                bram_addr_q   <= bus.mem_addr[13:2]
                                                 - BRAM_BASE[13:2];
                                bram_wdata_q  <= bus.mem_wdata;
                            end
                            RGN_IO: begin
                                state_q    <= ST_IO_WAIT;
                                io_valid_q <= 1'b1;
                                io_addr_q  <= bus.mem_addr[7:0]
                                              - IO_BASE[7:0];
                                io_wstrb_q <= bus.mem_wstrb;
                                io_wdata_q <= bus.mem_wdata;
                            end
                            default: begin
                                state_q     <= ST_RESP;
                                mem_ready_q <= 1'b1;
                                mem_rdata_q <= '0;
                                bus_err_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_BRAM_WAIT: begin
                    // Reads spend one extra cycle for the BRAM output register.
                    if (!wr_q && !rd_pend_q) begin
                        rd_pend_q <= 1'b1;
                    end else begin
                        state_q     <= ST_RESP;
                        mem_ready_q <= 1'b1;
                        mem_rdata_q <= wr_q ? 32'h0 : bram_rdata;
                    end
                end
                ST_IO_WAIT: begin
                    if (io_ready) begin
                        state_q     <= ST_RESP;
                        io_valid_q  <= 1'b0;
                        mem_ready_q <= 1'b1;
                        mem_rdata_q <= wr_q ? 32'h0 : io_rdata;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (wd_expire) begin
                        state_q     <= ST_RESP;
                        io_valid_q  <= 1'b0;
                        mem_ready_q <= 1'b1;
                        mem_rdata_q <= DEADBEEF;
                        bus_err_q   <= 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bram_select   = bram_select_q;
    assign bram_we       = bram_we_q;
    assign bram_rd       = bram_rd_q;
    assign bram_addr     = bram_addr_q;
    assign bram_wdata    = bram_wdata_q;
    assign io_valid      = io_valid_q;
    assign io_addr       = io_addr_q;
    assign io_wstrb      = io_wstrb_q;
    assign io_wdata      = io_wdata_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_boot_bus_ctrl.sv
// tb_boot_bus_ctrl: randomized self-checking bench for boot_bus_ctrl
// with a word-array reference model and a registered BRAM model.
module tb_boot_bus_ctrl;

    localparam int LAT_LIMIT = 1000;

    typedef struct packed {
        int          lat;
        int          nsel;
        int          sel_cyc;
        int          nio;
        logic [31:0] rdata;
        logic [11:0] sel_addr;
        logic [3:0]  sel_we;
        logic        sel_rd;
        logic [31:0] sel_wdata;
        logic [7:0]  io_addr;
        logic [3:0]  io_wstrb;
        logic [31:0] io_wdata;
        logic        ready_after;
        logic        err;
    } obs_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        bram_select;
    logic [3:0]  bram_we;
    logic        bram_rd;
    logic [11:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata = '0;
    logic        io_valid;
    logic [7:0]  io_addr;
    logic [3:0]  io_wstrb;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata = '0;
    logic        io_ready = 1'b0;
    logic        bus_err;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] dev_mem [0:4095];
    logic [31:0] dev_tmp;
    logic [31:0] ref_mem [0:511];
    bit          ref_err = 1'b0;

    always #5 clk = ~clk;

    boot_bus_ctrl_if bus ();

    boot_bus_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .bram_select (bram_select),
        .bram_we     (bram_we),
        .bram_rd     (bram_rd),
        .bram_addr   (bram_addr),
        .bram_wdata  (bram_wdata),
        .bram_rdata  (bram_rdata),
        .io_valid    (io_valid),
        .io_addr     (io_addr),
        .io_wstrb    (io_wstrb),
        .io_wdata    (io_wdata),
        .io_rdata    (io_rdata),
        .io_ready    (io_ready),
        .bus_err     (bus_err)
    );

    // Block RAM with registered read port and no reset.
    always @(posedge clk) begin
        if (bram_select) begin
            dev_tmp = dev_mem[bram_addr];
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) dev_tmp[8*b +: 8] = bram_wdata[8*b +: 8];
            dev_mem[bram_addr] <= dev_tmp;
            if (bram_rd) bram_rdata <= dev_mem[bram_addr];
        end
    end

    function automatic int region(input logic [31:0] a);
        if (a < 32'd2048) return 0;
        if (a >= 32'h8000_0000 && a <= 32'h8000_00FF) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Drive one request, act as the IO slave, record what the DUT did.
    task automatic txn(input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input int io_lat,
                       input logic [31:0] io_d, output obs_t o);
        int io_cnt;
        o = '0;
        io_cnt = 0;
        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = wd;
        bus.mem_wstrb = ws;
        for (int c = 1; c <= LAT_LIMIT; c++) begin
            @(posedge clk); #1;
            bus.mem_addr  = $urandom;
            bus.mem_wdata = $urandom;
            bus.mem_wstrb = 4'($urandom);
            if (bram_select) begin
                o.nsel      = o.nsel + 1;
                o.sel_cyc   = c;
                o.sel_addr  = bram_addr;
                o.sel_we    = bram_we;
                o.sel_rd    = bram_rd;
                o.sel_wdata = bram_wdata;
            end
            if (io_valid) begin
                o.nio      = o.nio + 1;
                o.io_addr  = io_addr;
                o.io_wstrb = io_wstrb;
                o.io_wdata = io_wdata;
                if (io_lat >= 0 && io_cnt == io_lat) begin
                    io_ready = 1'b1;
                    io_rdata = io_d;
                end else begin
                    io_ready = 1'b0;
                    io_rdata = $urandom;
                end
                io_cnt++;
            end else begin
                io_ready = 1'b0;
            end
            if (bus.mem_ready) begin
                o.lat   = c;
                o.rdata = bus.mem_rdata;
                break;
            end
        end
        bus.mem_valid = 1'b0;
        io_ready = 1'b0;
        @(posedge clk); #1;
        o.ready_after = bus.mem_ready;
        o.err = bus_err;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.mem_ready, bus.mem_rdata, bus_err} !== 34'h0) begin
            tests_failed++;
            $display("FAIL reset_mem: ready=%b rdata=%h err=%b, need 0",
                     bus.mem_ready, bus.mem_rdata, bus_err);
        end
        tests_run++;
        if ({bram_select, bram_we, bram_rd, bram_addr, bram_wdata} !== 50'h0) begin
            tests_failed++;
            $display("FAIL reset_bram: sel=%b we=%h rd=%b addr=%h wd=%h, need 0",
                     bram_select, bram_we, bram_rd, bram_addr, bram_wdata);
        end
        tests_run++;
        if ({io_valid, io_addr, io_wstrb, io_wdata} !== 45'h0) begin
            tests_failed++;
            $display("FAIL reset_io: v=%b a=%h s=%h d=%h, need 0",
                     io_valid, io_addr, io_wstrb, io_wdata);
        end
        resetn = 1'b1;
    endtask

    task automatic test_bram_wr_rd();
        obs_t o;
        txn(32'h10, 32'h1234_5678, 4'hF, 0, 0, o);
        ref_mem[4] = 32'h1234_5678;
        tests_run++;
        if ({o.nsel, o.sel_cyc, o.sel_addr, o.sel_we, o.sel_rd, o.sel_wdata}
            !== {32'd1, 32'd1, 12'd4, 4'hF, 1'b0, 32'h1234_5678}) begin
            tests_failed++;
            $display("FAIL bram_wr_strobe: n=%0d cyc=%0d a=%h we=%h rd=%b d=%h, need 1 1 4 f 0 12345678",
                     o.nsel, o.sel_cyc, o.sel_addr, o.sel_we, o.sel_rd, o.sel_wdata);
        end
        tests_run++;
        if (o.lat !== 2 || o.ready_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL bram_wr_ready: lat=%0d after=%b, need 2 0", o.lat, o.ready_after);
        end
        txn(32'h10, 32'h0, 4'h0, 0, 0, o);
        tests_run++;
        if ({o.nsel, o.sel_addr, o.sel_we, o.sel_rd} !== {32'd1, 12'd4, 4'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL bram_rd_strobe: n=%0d a=%h we=%h rd=%b, need 1 4 0 1",
                     o.nsel, o.sel_addr, o.sel_we, o.sel_rd);
        end
        tests_run++;
        if (o.lat !== 3 || o.rdata !== 32'h1234_5678 || o.ready_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL bram_rd: lat=%0d rdata=%h after=%b, need 3 12345678 0",
                     o.lat, o.rdata, o.ready_after);
        end
    endtask

    task automatic test_byte_write();
        obs_t o;
        txn(32'h10, 32'hAABB_CCDD, 4'b0100, 0, 0, o);
        ref_mem[4] = merge(ref_mem[4], 32'hAABB_CCDD, 4'b0100);
        txn(32'h10, 32'h0, 4'h0, 0, 0, o);
        tests_run++;
        if (o.rdata !== 32'h12BB_5678) begin
            tests_failed++;
            $display("FAIL byte_write: rdata=%h, need 12bb5678", o.rdata);
        end
    endtask

    task automatic test_io_stall();
        obs_t o;
        txn(32'h8000_0004, 32'h0, 4'h0, 5, 32'h55, o);
        tests_run++;
        if (o.io_addr !== 8'h04 || o.nio !== 6 || o.nsel !== 0) begin
            tests_failed++;
            $display("FAIL io_stall_bus: io_addr=%h nio=%0d nsel=%0d, need 04 6 0",
                     o.io_addr, o.nio, o.nsel);
        end
        tests_run++;
        if (o.lat !== 7 || o.rdata !== 32'h55 || o.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL io_stall_resp: lat=%0d rdata=%h err=%b, need 7 55 0",
                     o.lat, o.rdata, o.err);
        end
    endtask

    task automatic test_unmapped();
        obs_t o;
        txn(32'h0000_0800, 32'h0, 4'h0, 0, 0, o);
        ref_err = 1'b1;
        tests_run++;
        if (o.nsel !== 0 || o.nio !== 0 || o.lat !== 1 || o.rdata !== 32'h0 || o.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL unmapped: nsel=%0d nio=%0d lat=%0d rdata=%h err=%b, need 0 0 1 0 1",
                     o.nsel, o.nio, o.lat, o.rdata, o.err);
        end
        txn(32'h10, 32'h0, 4'h0, 0, 0, o);
        tests_run++;
        if (o.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky: err=%b, need 1", o.err);
        end
    endtask

    task automatic test_boundaries();
        obs_t o;
        logic [31:0] addrs [5];
        int exp_lat [5];
        int exp_sel [5];
        int exp_io [5];
        addrs = '{32'h7FC, 32'h800, 32'h8000_00FF, 32'h8000_0100, 32'hFFFF_FFFC};
        exp_lat = '{3, 1, 2, 1, 1};
        exp_sel = '{1, 0, 0, 0, 0};
        exp_io  = '{0, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            txn(addrs[i], 32'h0, 4'h0, 0, 32'hC0DE_0000 + 32'(i), o);
            tests_run++;
            if (o.lat !== exp_lat[i] || o.nsel !== exp_sel[i] || o.nio !== exp_io[i]) begin
                tests_failed++;
                $display("FAIL boundary %h: lat=%0d nsel=%0d nio=%0d, need %0d %0d %0d",
                         addrs[i], o.lat, o.nsel, o.nio, exp_lat[i], exp_sel[i], exp_io[i]);
            end
        end
        tests_run++;
        if (o.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL boundary_err: err=%b, need 1", o.err);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [31:0] a, wd, iod, exp_rd;
        logic [3:0] ws;
        int k, rg, iol, exp_lat;
        logic [31:0] picks [7];
        picks = '{32'h7FC, 32'h7FF, 32'h800, 32'h8000_00FF,
                  32'h8000_0100, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 4) a = 32'($urandom_range(0, 511)) * 4 + 32'($urandom_range(0, 3));
            else if (k <= 6) a = 32'h8000_0000 + 32'($urandom_range(0, 255));
            else if (k == 7) a = 32'h800 + 32'($urandom_range(0, 4000));
            else if (k == 8) a = 32'h8000_0100 + 32'($urandom_range(0, 4000));
            else a = picks[$urandom_range(0, 6)];
            ws  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            wd  = $urandom;
            iod = $urandom;
            iol = $urandom_range(0, 6);
            rg  = region(a);
            txn(a, wd, ws, iol, iod, o);
            if (rg == 0) begin
                exp_lat = (ws == 0) ? 3 : 2;
                exp_rd  = ref_mem[a >> 2];
                ref_mem[a >> 2] = merge(ref_mem[a >> 2], wd, ws);
            end else if (rg == 1) begin
                exp_lat = iol + 2;
                exp_rd  = iod;
            end else begin
                exp_lat = 1;
                exp_rd  = 32'h0;
                ref_err = 1'b1;
            end
            tests_run++;
            if (o.lat !== exp_lat || o.ready_after !== 1'b0 || o.err !== ref_err) begin
                tests_failed++;
                $display("FAIL rand_resp %h ws=%h: lat=%0d after=%b err=%b, need %0d 0 %b",
                         a, ws, o.lat, o.ready_after, o.err, exp_lat, ref_err);
            end
            if (ws == 0) begin
                tests_run++;
                if (o.rdata !== exp_rd) begin
                    tests_failed++;
                    $display("FAIL rand_rdata %h: rdata=%h, need %h", a, o.rdata, exp_rd);
                end
            end
            tests_run++;
            if (rg == 0) begin
                if (o.nsel !== 1 || o.sel_cyc !== 1 || o.nio !== 0 ||
                    o.sel_addr !== 12'(a >> 2) || o.sel_we !== ws ||
                    o.sel_rd !== (ws == 0) || (ws != 0 && o.sel_wdata !== wd)) begin
                    tests_failed++;
                    $display("FAIL rand_bram %h: n=%0d cyc=%0d nio=%0d a=%h we=%h rd=%b d=%h, need 1 1 0 %h %h %b %h",
                             a, o.nsel, o.sel_cyc, o.nio, o.sel_addr, o.sel_we, o.sel_rd,
                             o.sel_wdata, 12'(a >> 2), ws, ws == 0, wd);
                end
            end else if (rg == 1) begin
                if (o.nsel !== 0 || o.nio !== iol + 1 || o.io_addr !== a[7:0] ||
                    o.io_wstrb !== ws || (ws != 0 && o.io_wdata !== wd)) begin
                    tests_failed++;
                    $display("FAIL rand_io %h: nsel=%0d nio=%0d a=%h s=%h d=%h, need 0 %0d %h %h %h",
                             a, o.nsel, o.nio, o.io_addr, o.io_wstrb, o.io_wdata,
                             iol + 1, a[7:0], ws, wd);
                end
            end else begin
                if (o.nsel !== 0 || o.nio !== 0) begin
                    tests_failed++;
                    $display("FAIL rand_none %h: nsel=%0d nio=%0d, need 0 0",
                             a, o.nsel, o.nio);
                end
            end
        end
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        txn(32'h8000_0010, 32'h0, 4'h0, -1, 0, o);
        ref_err = 1'b1;
        tests_run++;
        if (o.lat !== 256 || o.nio !== 255 || o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout: lat=%0d nio=%0d rdata=%h err=%b, need 256 255 deadbeef 1",
                     o.lat, o.nio, o.rdata, o.err);
        end
    endtask
`endif

    task automatic test_reset_mid_io();
        obs_t o;
        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h8000_0020;
        bus.mem_wstrb = 4'h0;
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (io_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_io_wait: io_valid=%b, need 1", io_valid);
        end
        resetn = 1'b0;
        bus.mem_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({io_valid, bus.mem_ready, bus_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL mid_io_reset: io_valid=%b ready=%b err=%b, need 0 0 0",
                     io_valid, bus.mem_ready, bus_err);
        end
        resetn = 1'b1;
        ref_err = 1'b0;
        txn(32'h10, 32'h0, 4'h0, 0, 0, o);
        tests_run++;
        if (o.lat !== 3 || o.rdata !== ref_mem[4] || o.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_rd: lat=%0d rdata=%h err=%b, need 3 %h 0",
                     o.lat, o.rdata, o.err, ref_mem[4]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) dev_mem[i] = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        test_reset();
        test_bram_wr_rd();
        test_byte_write();
        test_io_stall();
        test_unmapped();
        test_boundaries();
        test_random();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_io();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
